seven_seg_count_control: RTL and testbench
==========================================

# seven_seg_count_control

Upstream control stage for the two-digit latched seven-segment display counter. Takes raw pushbutton and switch inputs from the board, debounces them, and runs a run/pause/idle state machine. Produces the display stage's one-cycle count-Enable strobe, its Blanking level (steady or flashing while paused) and a synchronous count-clear pulse for its counter.

## Interface
Parameters:
- TICK_DIV, 4: clock cycles per Enable strobe while running; legal values are ≥ 2.
- DB_CYCLES, 3: consecutive synchronized samples needed to accept a new input level; legal values are ≥ 1.
- FLASH_CYCLES, 6: clock cycles per half-period of the pause flash; legal values are ≥ 1.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- Run_Stop_btn  in  1  raw, bouncing run/stop pushbutton; active high.
- Clear_btn  in  1  raw, bouncing clear pushbutton; active high.
- Blank_sw  in  1  raw blanking switch level.
- Enable  out  1  one-cycle strobe to the display counter's Enable.
- Blanking  out  1  display blanking level.
- Count_Clear  out  1  one-cycle pulse driving the display counter's synchronous reset.
- Running  out  1  high while the state is RUN.

## Operation
- Reset (reset=0) clears all registers immediately:
  - Enable, Blanking, Count_Clear and Running are 0.
  - State is IDLE.
  - Synchronizers, debounced levels and edge-detect registers are 0.
  - Prescaler, flash counter and flash phase are 0.
- Each raw input passes through a 2-flop synchronizer producing s. Each input then has its own debouncer with a counter cnt and a debounced level db:
  - s == db: cnt ← 0.
  - s != db and cnt < DB_CYCLES-1: cnt ← cnt+1.
  - s != db and cnt == DB_CYCLES-1: db ← s, cnt ← 0.
- Press events: run_press = rising edge of db(Run_Stop_btn); clear_press = rising edge of db(Clear_btn). Each is exactly one cycle per debounced press. Falling edges are ignored.
- FSM states are IDLE, RUN and PAUSE:
  - IDLE + run_press → RUN, with prescaler ← 0.
  - RUN + run_press → PAUSE, with flash counter ← 0 and phase ← 0.
  - PAUSE + run_press → RUN; the prescaler resumes from its held value.
  - Any state + clear_press → IDLE, with prescaler ← 0 and Count_Clear ← 1 for one cycle.
  - Clear has priority over a simultaneous run_press.
- Prescaler behaviour:
  - In RUN it counts 0..TICK_DIV-1 and wraps to 0.
  - In PAUSE it holds its value.
  - In IDLE it is held at 0.
- Enable (registered) ← (state==RUN && prescaler==TICK_DIV-1 && !clear_press). It is never high in two consecutive cycles.
- Flash behaviour:
  - In PAUSE, the flash counter counts 0..FLASH_CYCLES-1; on wrap, phase toggles.
  - Outside PAUSE, the flash counter and phase are held at 0.
- Blanking (registered) ← db(Blank_sw) | (state==PAUSE && phase).
- Running (registered) ← next state == RUN.

## Timing
- Raw input change held stable from before edge k:
  - Debounced level changes at edge k+DB_CYCLES+1.
  - The resulting FSM transition and registered outputs update at edge k+DB_CYCLES+2.
- Bounce shorter than DB_CYCLES synchronized samples produces no event.
- Enable period in RUN is exactly TICK_DIV cycles. The first Enable after IDLE→RUN occurs TICK_DIV cycles after the transition edge.
- Pause and resume preserve phase: total RUN cycles between strobes equals TICK_DIV.
- Blank_sw-driven Blanking follows the Blank_sw debounced level one cycle later. Total latency from raw input is DB_CYCLES+2 edges.
- Flash period in PAUSE is 2×FLASH_CYCLES cycles. The display is visible (phase 0) for the first FLASH_CYCLES cycles after entering PAUSE.
- Reset asserted mid-operation forces all outputs to 0 asynchronously, with no Count_Clear pulse. After release, the block is in IDLE and requires a fresh press.

## Test plan
- Reset, then hold Run_Stop_btn high for 10 cycles with defaults (TICK_DIV=4, DB_CYCLES=3) → Running rises 5 cycles after the raw rise; Enable pulses every 4 cycles thereafter.
- Toggle Run_Stop_btn high/low every cycle for 20 cycles (bounce) → no state change, Enable stays 0, Running stays 0.
- RUN for 6 cycles past an Enable, press run/stop (→ PAUSE), wait 30 cycles, press again → no Enable during PAUSE; Blanking toggles every 6 cycles starting visible; after resume, the next Enable arrives when 4 RUN cycles have accumulated since the previous one.
- Run_Stop_btn and Clear_btn rise in the same cycle while in PAUSE → exactly one Count_Clear pulse, state IDLE, Running 0, Blanking 0, no Enable.
- Blank_sw held high during RUN → Blanking=1 steady 5 cycles after the raw rise; Enable continues unaffected.
- Drive reset low for 1 cycle while Enable is high and Count_Clear is pending → all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/seven_seg_count_control.sv
// Control stage ahead of the two-digit latched seven-segment counter: input conditioning,
// run/pause/idle sequencing, and the Enable strobe, Blanking level and Count_Clear pulse.
`timescale 1ns/1ps
module seven_seg_count_control #(
  parameter int TICK_DIV     = 4,
  parameter int DB_CYCLES    = 3,
  parameter int FLASH_CYCLES = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Run_Stop_btn,
  input  logic       Clear_btn,
  input  logic       Blank_sw,
  output logic       Enable,
  output logic       Blanking,
  output logic       Count_Clear,
  output logic       Running,
  output logic [1:0] dbg_state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Input lanes: bit 0 run/stop button, bit 1 clear button, bit 2 blank switch.
  logic [2:0]         raw;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         db_q, db_d;
  logic [2:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0]         db_prev_q;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] flash_q, flash_d;
  logic          phase_q, phase_d;

  logic enable_q, enable_d;
  logic blank_q, blank_d;
  logic clear_q;
  logic running_q;

  logic run_press;
  logic clear_press;

  assign raw = {Blank_sw, Clear_btn, Run_Stop_btn};

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  assign run_press   = db_q[0] & ~db_prev_q[0];
  assign clear_press = db_q[1] & ~db_prev_q[1];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    flash_d = '0;
    phase_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (run_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        if (run_press) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (run_press) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
    if (clear_press) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end
    // Flash timing only advances while staying in PAUSE; entering PAUSE restarts visible.
    if (state_q == ST_PAUSE && state_d == ST_PAUSE) begin
      if (flash_q == FLASH_MAX) begin
        flash_d = '0;
        phase_d = ~phase_q;
      end else begin
        flash_d = flash_q + FW'(1);
        phase_d = phase_q;
      end
    end
  end

  assign enable_d = (state_q == ST_RUN) && (presc_q == PRESC_MAX) && !clear_press;
  assign blank_d  = db_q[2] | ((state_d == ST_PAUSE) && phase_d);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      db_prev_q <= '0;
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      flash_q   <= '0;
      phase_q   <= 1'b0;
      enable_q  <= 1'b0;
      blank_q   <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      db_prev_q <= db_q[1:0];
      state_q   <= state_d;
      presc_q   <= presc_d;
      flash_q   <= flash_d;
      phase_q   <= phase_d;
      enable_q  <= enable_d;
      blank_q   <= blank_d;
      clear_q   <= clear_press;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign Enable      = enable_q;
  assign Blanking    = blank_q;
  assign Count_Clear = clear_q;
  assign Running     = running_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seven_seg_count_control.sv
// Bench for seven_seg_count_control: directed scenarios with literal timing expectations,
// then randomized button/switch activity against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_seven_seg_count_control;

  localparam int TICK_DIV     = 4;
  localparam int DB_CYCLES    = 3;
  localparam int FLASH_CYCLES = 6;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Run_Stop_btn = 1'b0;
  logic       Clear_btn = 1'b0;
  logic       Blank_sw = 1'b0;
  logic       Enable, Blanking, Count_Clear, Running;
  logic [1:0] dbg_state_o;

  seven_seg_count_control #(
    .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES), .FLASH_CYCLES(FLASH_CYCLES)
  ) dut (
    .clock(clock), .reset(reset),
    .Run_Stop_btn(Run_Stop_btn), .Clear_btn(Clear_btn), .Blank_sw(Blank_sw),
    .Enable(Enable), .Blanking(Blanking), .Count_Clear(Count_Clear),
    .Running(Running), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs are seen through a 2-sample delay, accepted after DB_CYCLES consecutive
  // disagreeing samples; presses act one cycle after acceptance.
  int m_st, m_acc, m_age;
  int m_s1[3], m_s2[3], m_db[3], m_mis[3];
  int m_rose[2];
  int e_en, e_blank, e_cc, e_run;

  task automatic model_reset();
    m_st = M_IDLE; m_acc = 0; m_age = 0;
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_mis[i] = 0;
    end
    m_rose[0] = 0; m_rose[1] = 0;
    e_en = 0; e_blank = 0; e_cc = 0; e_run = 0;
  endtask

  task automatic model_step();
    int rp, cp, old_st, new_st, old_db;
    int raw[3];
    raw[0] = int'(Run_Stop_btn); raw[1] = int'(Clear_btn); raw[2] = int'(Blank_sw);
    rp = m_rose[0];
    cp = m_rose[1];
    old_st = m_st;
    e_en = (old_st == M_RUN && m_acc == TICK_DIV - 1 && cp == 0) ? 1 : 0;
    e_cc = cp;
    if (old_st == M_RUN) m_acc = (m_acc + 1) % TICK_DIV;
    if (cp != 0) new_st = M_IDLE;
    else if (rp != 0) new_st = (old_st == M_RUN) ? M_PAUSE : M_RUN;
    else new_st = old_st;
    if (cp != 0) m_acc = 0;
    m_age = (old_st == M_PAUSE && new_st == M_PAUSE) ? m_age + 1 : 0;
    e_blank = (m_db[2] != 0 || (new_st == M_PAUSE && ((m_age / FLASH_CYCLES) % 2) == 1)) ? 1 : 0;
    e_run = (new_st == M_RUN) ? 1 : 0;
    m_st = new_st;
    for (int i = 0; i < 3; i++) begin
      old_db = m_db[i];
      if (m_s2[i] != m_db[i]) begin
        m_mis[i]++;
        if (m_mis[i] >= DB_CYCLES) begin
          m_db[i] = m_s2[i];
          m_mis[i] = 0;
        end
      end else begin
        m_mis[i] = 0;
      end
      if (i < 2) m_rose[i] = (m_db[i] == 1 && old_db == 0) ? 1 : 0;
    end
    for (int i = 0; i < 3; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic prev_en = 1'b0;
  int run_since = 0;

  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      if (!reset) model_reset();
      else model_step();
      cyc++;
      #1;
      chk("enable", int'(Enable), e_en);
      chk("blanking", int'(Blanking), e_blank);
      chk("count_clear", int'(Count_Clear), e_cc);
      chk("running", int'(Running), e_run);
      chk("state", int'(dbg_state_o), m_st);
      chk("enable_gap", int'(prev_en && Enable), 0);
      prev_en = Enable;
      if (!reset) begin
        run_since = 0;
      end else begin
        if (Count_Clear) run_since = 0;
        if (Enable) begin
          chk("run_cycles_between_strobes", run_since, TICK_DIV);
          run_since = 0;
        end
        if (Running) run_since++;
      end
    end
  end

  // ---------------- driver helpers ----------------
  // sel: 0 Running high, 1 Enable high, 2 Blanking high, 3 Running low
  task automatic wait_sig(input int sel, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if ((sel == 0 && Running) || (sel == 1 && Enable) ||
          (sel == 2 && Blanking) || (sel == 3 && !Running)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int r, at, p, r2, e, cnt_en, cnt_cc, cnt_bl, saw_run;
    int hold[3];
    logic lvl[3];

    repeat (2) @(negedge clock);
    chk("reset_enable", int'(Enable), 0);
    chk("reset_running", int'(Running), 0);
    chk("reset_blanking", int'(Blanking), 0);
    chk("reset_count_clear", int'(Count_Clear), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Hold run/stop: RUN five edges after the raw rise, strobes every TICK_DIV.
    Run_Stop_btn = 1'b1;
    r = cyc;
    wait_sig(0, 20, at);
    chk("t1_running_latency", at, r + 6);
    wait_sig(1, 20, at);
    chk("t1_first_enable", at, r + 10);
    wait_sig(1, 20, at);
    chk("t1_second_enable", at, r + 14);
    Run_Stop_btn = 1'b0;

    Clear_btn = 1'b1;
    repeat (6) @(negedge clock);
    Clear_btn = 1'b0;
    repeat (10) @(negedge clock);

    // Bounce on run/stop must be rejected.
    saw_run = 0; cnt_en = 0;
    for (int i = 0; i < 30; i++) begin
      Run_Stop_btn = (i < 20) ? ~Run_Stop_btn : 1'b0;
      @(negedge clock);
      if (Running) saw_run = 1;
      if (Enable) cnt_en++;
    end
    chk("t2_bounce_running", saw_run, 0);
    chk("t2_bounce_enable", cnt_en, 0);

    // Pause mid-period, flash, resume with preserved prescaler phase.
    Run_Stop_btn = 1'b1;
    repeat (4) @(negedge clock);
    Run_Stop_btn = 1'b0;
    wait_sig(1, 20, e);
    repeat (5) @(negedge clock);
    Run_Stop_btn = 1'b1;
    r = cyc;
    wait_sig(3, 20, p);
    chk("t3_pause_entry", p, r + 6);
    chk("t3_pause_entry_strobe_gap", p, e + 11);
    Run_Stop_btn = 1'b0;
    chk("t3_blank_j0", int'(Blanking), 0);
    cnt_en = 0;
    for (int j = 1; j < 30; j++) begin
      @(negedge clock);
      if (Enable) cnt_en++;
      if (j == 5 || j == 6 || j == 11 || j == 12 || j == 18)
        chk($sformatf("t3_blank_j%0d", j), int'(Blanking), (j / 6) % 2);
    end
    chk("t3_no_enable_in_pause", cnt_en, 0);
    Run_Stop_btn = 1'b1;
    r2 = cyc;
    wait_sig(1, 20, at);
    chk("t3_resume_enable", at, r2 + 7);
    Run_Stop_btn = 1'b0;

    // Pause, then run/stop and clear together: clear wins.
    repeat (4) @(negedge clock);
    Run_Stop_btn = 1'b1;
    repeat (4) @(negedge clock);
    Run_Stop_btn = 1'b0;
    wait_sig(3, 20, at);
    repeat (3) @(negedge clock);
    Run_Stop_btn = 1'b1;
    Clear_btn = 1'b1;
    cnt_cc = 0; cnt_en = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (i == 7) begin
        Run_Stop_btn = 1'b0;
        Clear_btn = 1'b0;
      end
      if (Count_Clear) cnt_cc++;
      if (Enable) cnt_en++;
    end
    chk("t4_one_clear_pulse", cnt_cc, 1);
    chk("t4_no_enable", cnt_en, 0);
    chk("t4_running_low", int'(Running), 0);
    chk("t4_blanking_low", int'(Blanking), 0);
    chk("t4_state_idle", int'(dbg_state_o), M_IDLE);

    // Blank switch during RUN.
    Run_Stop_btn = 1'b1;
    wait_sig(0, 20, at);
    Run_Stop_btn = 1'b0;
    repeat (2) @(negedge clock);
    Blank_sw = 1'b1;
    r = cyc;
    wait_sig(2, 20, at);
    chk("t5_blank_latency", at, r + 6);
    cnt_bl = 0; cnt_en = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (Blanking) cnt_bl++;
      if (Enable) cnt_en++;
    end
    chk("t5_blank_steady", cnt_bl, 12);
    chk("t5_enable_unaffected", cnt_en, 3);
    Blank_sw = 1'b0;
    repeat (8) @(negedge clock);

    // Async reset while Enable is high and a clear press is in flight.
    Clear_btn = 1'b1;
    wait_sig(1, 6, at);
    chk("t6_enable_high_before_reset", int'(Enable), 1);
    chk("t6_clear_still_pending", int'(Count_Clear), 0);
    reset = 1'b0;
    Clear_btn = 1'b0;
    #1;
    chk("t6_async_enable", int'(Enable), 0);
    chk("t6_async_running", int'(Running), 0);
    chk("t6_async_blanking", int'(Blanking), 0);
    chk("t6_async_count_clear", int'(Count_Clear), 0);
    @(negedge clock);
    reset = 1'b1;
    cnt_cc = 0; saw_run = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (Count_Clear) cnt_cc++;
      if (Running) saw_run = 1;
    end
    chk("t6_no_clear_after_reset", cnt_cc, 0);
    chk("t6_idle_after_reset", saw_run, 0);
    chk("t6_state_idle", int'(dbg_state_o), M_IDLE);

    // Randomized activity, including bounces and one mid-run reset pulse.
    lvl[0] = 1'b0; lvl[1] = 1'b0; lvl[2] = 1'b0;
    hold[0] = 1; hold[1] = 30; hold[2] = 5;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          lvl[i] = ~lvl[i];
          if (i == 1) hold[i] = lvl[i] ? int'($urandom_range(1, 8)) : int'($urandom_range(20, 80));
          else hold[i] = int'($urandom_range(1, 12));
        end
      end
      Run_Stop_btn = lvl[0];
      Clear_btn = lvl[1];
      Blank_sw = lvl[2];
      if (c == 400) reset = 1'b0;
      if (c == 401) reset = 1'b1;
    end
    Run_Stop_btn = 1'b0;
    Clear_btn = 1'b0;
    Blank_sw = 1'b0;
    repeat (10) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
